// File: rtl/mrd_src_framer_pkg.sv
// Shared types and constants for the Source-phase output framer.
// Holds the framer state encoding, widths and saturation limits.
package mrd_src_pkt;

    localparam int W_IN      = 30;
    localparam int W_OUT     = 18;
    localparam int W_EXP     = 6;
    localparam int W_SH      = 4;
    localparam int W_LEN     = 12;
    localparam int SHIFT_MAX = 12;

    localparam int SAT_MAX = (1 << (W_OUT - 1)) - 1;
    localparam int SAT_MIN = -(1 << (W_OUT - 1));

    typedef enum logic [1:0] {
        IDLE,
        PKT,
        DISCARD
    } state_t;

    function automatic logic [W_SH-1:0] clamp_shift(
        input logic [W_SH-1:0] s
    );
        if (s > W_SH'(SHIFT_MAX)) begin
            return W_SH'(SHIFT_MAX);
        end
        return s;
    endfunction

endpackage

// File: rtl/mrd_rnd_sat.sv
// Two-stage round-half-up, arithmetic right shift and saturation.
// Stage 1 registers the rounded sum, stage 2 the clipped result.
module mrd_rnd_sat #(
    parameter int W_IN  = 30,
    parameter int W_OUT = 18
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en1,
    input  logic                                en2,
    input  logic signed [W_IN-1:0]              x,
    input  logic        [mrd_src_pkt::W_SH-1:0] s,
    output logic signed [W_OUT-1:0]             y,
    output logic                                clip
);
    import mrd_src_pkt::*;

    localparam logic signed [W_IN:0] Y_MAX =
        {{(W_IN - W_OUT + 2){1'b0}}, {(W_OUT - 1){1'b1}}};
    localparam logic signed [W_IN:0] Y_MIN =
        {{(W_IN - W_OUT + 2){1'b1}}, {(W_OUT - 1){1'b0}}};

    logic signed [W_IN:0]    bias;
    logic signed [W_IN:0]    t_d;
    logic signed [W_IN:0]    t_q;
    logic signed [W_IN:0]    sh_v;
    logic        [W_SH-1:0]  s_q;
    logic signed [W_OUT-1:0] y_d;
    logic                    clip_d;

    always_comb begin
        bias = '0;
        if (s != '0) begin
            bias = (W_IN + 1)'(1) << (s - 1'b1);
        end
    end

    // One guard bit keeps the rounding add from wrapping.
    assign t_d  = {x[W_IN-1], x} + bias;
    assign sh_v = t_q >>> s_q;

    always_comb begin
        y_d    = sh_v[W_OUT-1:0];
        clip_d = 1'b0;
        if (sh_v > Y_MAX) begin
            y_d    = Y_MAX[W_OUT-1:0];
            clip_d = 1'b1;
        end else if (sh_v < Y_MIN) begin
            y_d    = Y_MIN[W_OUT-1:0];
            clip_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_q  <= '0;
            s_q  <= '0;
            y    <= '0;
            clip <= 1'b0;
        end else begin
            if (en1) begin
                t_q <= t_d;
                s_q <= s;
            end
            if (en2) begin
                y    <= y_d;
                clip <= clip_d;
            end
        end
    end

endmodule

// File: rtl/mrd_src_framer.sv
// Re-frames the memory top's Source stream into 18-bit packets with
// per-packet requantisation, length checking and saturation report.
module mrd_src_framer #(
    parameter int W_IN  = mrd_src_pkt::W_IN,
    parameter int W_OUT = mrd_src_pkt::W_OUT,
    parameter int W_EXP = mrd_src_pkt::W_EXP
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 src_valid,
    input  logic                                 src_sop,
    input  logic                                 src_eop,
    input  logic signed [W_IN-1:0]               src_real,
    input  logic signed [W_IN-1:0]               src_imag,
    input  logic signed [W_EXP-1:0]              src_exp,
    input  logic        [mrd_src_pkt::W_LEN-1:0] dftpts,
    input  logic        [mrd_src_pkt::W_SH-1:0]  shift_amt,
    output logic                                 out_valid,
    output logic                                 out_sop,
    output logic                                 out_eop,
    output logic signed [W_OUT-1:0]              out_real,
    output logic signed [W_OUT-1:0]              out_imag,
    output logic signed [W_EXP:0]                out_exp,
    output logic                                 out_sat,
    output logic                                 len_err
);
    import mrd_src_pkt::*;

    state_t state_q, state_d;

    logic [W_LEN-1:0] cnt_q, cnt_d;
    logic [W_LEN-1:0] len_q, len_d;
    logic [W_LEN-1:0] idx, lim;
    logic [W_SH-1:0]  sh_q, sh_d, sh_use;

    logic start, emit, e_sop, e_eop, e_lerr;

    logic signed [W_EXP:0] exp_new, s1_exp;
    logic s1_valid, s1_sop, s1_eop, s1_lerr;
    logic sticky_q, clip_re, clip_im, clip_any;

    // A sop sample uses the freshly sampled parameters, not the latches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sh_d    = sh_q;
        start   = 1'b0;
        emit    = 1'b0;
        e_sop   = 1'b0;
        e_eop   = 1'b0;
        e_lerr  = 1'b0;
        idx     = cnt_q + 1'b1;
        lim     = len_q - 1'b1;
        if (src_valid) begin
            unique case (state_q)
                IDLE: start = src_sop;
                PKT: begin
                    start  = src_sop;
                    emit   = 1'b1;
                    e_lerr = src_sop;
                end
                DISCARD: begin
                    start = src_sop;
                    if (!src_sop && src_eop) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
            if (start) begin
                len_d   = dftpts;
                sh_d    = clamp_shift(shift_amt);
                idx     = '0;
                lim     = dftpts - 1'b1;
                emit    = 1'b1;
                e_sop   = 1'b1;
                state_d = PKT;
            end
            if (emit) begin
                cnt_d = idx;
                if (src_eop) begin
                    e_eop   = 1'b1;
                    state_d = IDLE;
                    if (idx != lim) begin
                        e_lerr = 1'b1;
                    end
                end else if (idx == lim) begin
                    e_eop   = 1'b1;
                    e_lerr  = 1'b1;
                    state_d = DISCARD;
                end else begin
                    state_d = PKT;
                end
            end
        end
    end

    assign sh_use  = start ? clamp_shift(shift_amt) : sh_q;
    assign exp_new = {src_exp[W_EXP-1], src_exp}
                   + $signed({{(W_EXP + 1 - W_SH){1'b0}}, sh_use});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sh_q    <= sh_d;
        end
    end

    mrd_rnd_sat #(
        .W_IN  (W_IN),
        .W_OUT (W_OUT)
    ) u_re (
        .clk   (clk),
        .rst_n (rst_n),
        .en1   (emit),
        .en2   (s1_valid),
        .x     (src_real),
        .s     (sh_use),
        .y     (out_real),
        .clip  (clip_re)
    );

    mrd_rnd_sat #(
        .W_IN  (W_IN),
        .W_OUT (W_OUT)
    ) u_im (
        .clk   (clk),
        .rst_n (rst_n),
        .en1   (emit),
        .en2   (s1_valid),
        .x     (src_imag),
        .s     (sh_use),
        .y     (out_imag),
        .clip  (clip_im)
    );

    assign clip_any = clip_re | clip_im;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sop    <= 1'b0;
            s1_eop    <= 1'b0;
            s1_lerr   <= 1'b0;
            s1_exp    <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            len_err   <= 1'b0;
            out_exp   <= '0;
            sticky_q  <= 1'b0;
        end else begin
            s1_valid  <= emit;
            s1_sop    <= e_sop;
            s1_eop    <= e_eop;
            s1_lerr   <= e_lerr;
            if (e_sop) begin
                s1_exp <= exp_new;
            end
            out_valid <= s1_valid;
            out_sop   <= s1_sop;
            out_eop   <= s1_eop;
            len_err   <= s1_lerr;
            if (s1_sop) begin
                out_exp <= s1_exp;
            end
            if (out_valid) begin
                sticky_q <= out_sop ? clip_any : (sticky_q | clip_any);
            end
        end
    end

    // Sticky covers earlier samples of this packet only; a sop sample starts fresh.
    assign out_sat = out_valid & out_eop
                   & (clip_any | (sticky_q & ~out_sop));

endmodule

// File: tb/tb_mrd_src_framer.sv
// Bench for mrd_src_framer: table vectors, directed framing sequences
// and randomized packets against a packet-level reference model.
module tb_mrd_src_framer;
    import mrd_src_pkt::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               src_valid, src_sop, src_eop;
    logic signed [29:0] src_real, src_imag;
    logic signed [5:0]  src_exp;
    logic [11:0]        dftpts;
    logic [3:0]         shift_amt;
    logic               out_valid, out_sop, out_eop, out_sat, len_err;
    logic signed [17:0] out_real, out_imag;
    logic signed [6:0]  out_exp;

    mrd_src_framer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (src_valid),
        .src_sop   (src_sop),
        .src_eop   (src_eop),
        .src_real  (src_real),
        .src_imag  (src_imag),
        .src_exp   (src_exp),
        .dftpts    (dftpts),
        .shift_amt (shift_amt),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_exp   (out_exp),
        .out_sat   (out_sat),
        .len_err   (len_err)
    );

    typedef struct {
        bit v, sop, eop, sat, lerr, dat;
        int re, im, ex;
    } rec_t;

    typedef struct {
        int sh, ex, x;
        int y, oe;
        bit sat;
    } row_t;

    typedef struct {
        bit has, sop, eop, sat;
        int y, ex;
    } tchk_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    rec_t  prev_e;
    tchk_t tab_n, tab_p;
    row_t  tbl[24];

    int n_valid, n_eop, n_lerr, n_sat;
    int in_sop_cyc, out_sop_cyc;

    int m_mode, m_n, m_plen, m_sh, m_hexp;
    bit m_sat;

    function automatic void rq(input int x, input int s,
                               output int y, output bit c);
        longint t;
        t = longint'(x);
        if (s > 0) t = t + (longint'(1) << (s - 1));
        t = t >>> s;
        c = 1'b0;
        if (t > SAT_MAX) begin
            t = SAT_MAX;
            c = 1'b1;
        end else if (t < SAT_MIN) begin
            t = SAT_MIN;
            c = 1'b1;
        end
        y = int'(t);
    endfunction

    task automatic chk_rec(input rec_t e, input string nm);
        bit bad;
        checks++;
        bad = (out_valid !== e.v) || (out_sop !== e.sop)
           || (out_eop !== e.eop) || (out_sat !== e.sat)
           || (len_err !== e.lerr) || (out_exp !== 7'(e.ex));
        if (e.v || e.dat) begin
            bad = bad || (out_real !== 18'(e.re))
                      || (out_imag !== 18'(e.im));
        end
        if (bad) begin
            errors++;
            $display("FAIL %s cyc=%0d got v%b s%b e%b sat%b le%b re=%0d im=%0d ex=%0d want v%b s%b e%b sat%b le%b re=%0d im=%0d ex=%0d",
                nm, cyc, out_valid, out_sop, out_eop, out_sat, len_err,
                out_real, out_imag, out_exp, e.v, e.sop, e.eop, e.sat,
                e.lerr, e.re, e.im, e.ex);
        end
    endtask

    task automatic chk_tab(input tchk_t t);
        checks++;
        if (out_valid !== 1'b1 || out_sop !== t.sop || out_eop !== t.eop
            || out_sat !== t.sat || out_real !== 18'(t.y)
            || out_imag !== 18'(t.y) || out_exp !== 7'(t.ex)) begin
            errors++;
            $display("FAIL table cyc=%0d got v%b s%b e%b sat%b re=%0d im=%0d ex=%0d want s%b e%b sat%b y=%0d ex=%0d",
                cyc, out_valid, out_sop, out_eop, out_sat, out_real,
                out_imag, out_exp, t.sop, t.eop, t.sat, t.y, t.ex);
        end
    endtask

    task automatic chk_cnt(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // Model one input cycle, clock it, then check the previous cycle's output.
    task automatic cycle();
        rec_t cur;
        int   yr, yi;
        bit   cr, ci, emit, lerr;
        cur  = '{default: 0};
        emit = 1'b0;
        lerr = 1'b0;
        if (!rst_n) begin
            m_mode = 0;
            m_n    = 0;
            m_hexp = 0;
            m_sat  = 1'b0;
        end else if (src_valid) begin
            if (src_sop) begin
                lerr   = (m_mode == 1);
                m_plen = int'(dftpts);
                m_sh   = (shift_amt > 12) ? 12 : int'(shift_amt);
                m_n    = 0;
                m_sat  = 1'b0;
                m_hexp = int'(src_exp) + m_sh;
                emit   = 1'b1;
                cur.sop = 1'b1;
                in_sop_cyc = cyc;
            end else if (m_mode == 1) begin
                emit = 1'b1;
            end else if (m_mode == 2 && src_eop) begin
                m_mode = 0;
            end
            if (emit) begin
                rq(int'(src_real), m_sh, yr, cr);
                rq(int'(src_imag), m_sh, yi, ci);
                m_sat   = m_sat | cr | ci;
                cur.v   = 1'b1;
                cur.re  = yr;
                cur.im  = yi;
                if (src_eop) begin
                    cur.eop = 1'b1;
                    lerr    = lerr | (m_n != m_plen - 1);
                    m_mode  = 0;
                end else if (m_n == m_plen - 1) begin
                    cur.eop = 1'b1;
                    lerr    = 1'b1;
                    m_mode  = 2;
                end else begin
                    m_mode = 1;
                end
                cur.sat  = cur.eop & m_sat;
                cur.lerr = lerr;
                m_n++;
            end
        end
        cur.ex = m_hexp;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            chk_rec('{dat: 1'b1, default: 0}, "reset");
        end else begin
            chk_rec(prev_e, "stream");
        end
        prev_e = cur;
        if (out_valid === 1'b1) begin
            n_valid++;
            if (out_eop === 1'b1) n_eop++;
            if (len_err === 1'b1) n_lerr++;
            if (out_sat === 1'b1) n_sat++;
            if (out_sop === 1'b1) out_sop_cyc = cyc + 1;
        end
        if (tab_p.has) chk_tab(tab_p);
        tab_p = tab_n;
        tab_n.has = 1'b0;
        cyc++;
    endtask

    task automatic drive(input bit v, input bit s, input bit e,
                         input int re, input int im);
        src_valid = v;
        src_sop   = s;
        src_eop   = e;
        src_real  = 30'(re);
        src_imag  = 30'(im);
        cycle();
    endtask

    task automatic gap_cycle();
        src_valid = 1'b0;
        src_sop   = 1'($urandom);
        src_eop   = 1'($urandom);
        src_real  = 30'($urandom);
        src_imag  = 30'($urandom);
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic clr();
        n_valid = 0;
        n_eop   = 0;
        n_lerr  = 0;
        n_sat   = 0;
    endtask

    // mode: 0 ramp, 1 random small, 2 random full-scale, 3 saturation probe
    task automatic send_pkt(input int dp, input int sh, input int ex,
                            input int len, input int gap, input int rst_at,
                            input int mode, input bit with_eop);
        int re, im;
        dftpts    = 12'(dp);
        shift_amt = 4'(sh);
        src_exp   = 6'(ex);
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < 3 && int'($urandom_range(99)) < gap; g++) begin
                gap_cycle();
            end
            unique case (mode)
                0: begin re = i; im = -i; end
                1: begin
                    re = int'($urandom_range(8191)) - 4096;
                    im = int'($urandom_range(8191)) - 4096;
                end
                2: begin
                    re = int'(30'($urandom)) - (1 << 29);
                    im = int'(30'($urandom)) - (1 << 29);
                end
                default: begin
                    re = (i == 5) ? 200000 : (i == 20) ? -200000 : i;
                    im = -i;
                end
            endcase
            if (i == rst_at) rst_n = 1'b0;
            drive(1, i == 0, with_eop && i == len - 1, re, im);
            rst_n = 1'b1;
            if (i == 0 && (mode == 1 || mode == 2)) begin
                dftpts    = 12'($urandom);
                shift_amt = 4'($urandom);
                src_exp   = 6'($urandom);
            end
        end
    endtask

    function automatic row_t mk(input int sh, input int ex, input int x,
                                input int y, input bit sat);
        return '{sh: sh, ex: ex, x: x, y: y, oe: ex + sh, sat: sat};
    endfunction

    initial begin
        int kind, dp, len;

        tbl[0]  = mk(4, -3, 24, 2, 0);
        tbl[1]  = mk(4, -3, 23, 1, 0);
        tbl[2]  = mk(4, -3, -24, -1, 0);
        tbl[3]  = mk(4, -3, -25, -2, 0);
        tbl[4]  = mk(4, -3, 0, 0, 0);
        tbl[5]  = mk(4, -3, 8, 1, 0);
        tbl[6]  = mk(4, -3, 7, 0, 0);
        tbl[7]  = mk(4, -3, -8, 0, 0);
        tbl[8]  = mk(4, -3, -9, -1, 0);
        tbl[9]  = mk(4, -3, 1000, 63, 0);
        tbl[10] = mk(4, -3, -1000, -62, 0);
        tbl[11] = mk(4, -3, 15, 1, 0);
        tbl[12] = mk(0, 5, 200000, 131071, 0);
        tbl[13] = mk(0, 5, -200000, -131072, 0);
        tbl[14] = mk(0, 5, 131071, 131071, 0);
        tbl[15] = mk(0, 5, 131072, 131071, 0);
        tbl[16] = mk(0, 5, -131072, -131072, 0);
        tbl[17] = mk(0, 5, -131073, -131072, 0);
        tbl[18] = mk(0, 5, 5, 5, 0);
        tbl[19] = mk(0, 5, -5, -5, 0);
        tbl[20] = mk(0, 5, 0, 0, 0);
        tbl[21] = mk(0, 5, 7, 7, 0);
        tbl[22] = mk(0, 5, 100, 100, 0);
        tbl[23] = mk(0, 5, -100, -100, 1);

        prev_e    = '{default: 0};
        tab_n     = '{default: 0};
        tab_p     = '{default: 0};
        rst_n     = 1'b0;
        src_valid = 1'b0;
        src_sop   = 1'b0;
        src_eop   = 1'b0;
        src_real  = '0;
        src_imag  = '0;
        src_exp   = '0;
        dftpts    = 12'd12;
        shift_amt = '0;
        in_sop_cyc  = 0;
        out_sop_cyc = 0;
        clr();
        repeat (3) cycle();
        rst_n = 1'b1;
        idle(2);

        clr();
        send_pkt(12, 0, 0, 12, 0, -1, 0, 1);
        chk_cnt("latency", out_sop_cyc - in_sop_cyc, 2);
        idle(3);
        chk_cnt("ramp_valid", n_valid, 12);
        chk_cnt("ramp_eop", n_eop, 1);
        chk_cnt("ramp_lerr", n_lerr, 0);

        clr();
        for (int i = 0; i < 24; i++) begin
            if (i % 12 == 0) begin
                dftpts    = 12'd12;
                shift_amt = 4'(tbl[i].sh);
                src_exp   = 6'(tbl[i].ex);
            end
            tab_n = '{has: 1'b1, sop: (i % 12 == 0), eop: (i % 12 == 11),
                      sat: tbl[i].sat, y: tbl[i].y, ex: tbl[i].oe};
            drive(1, i % 12 == 0, i % 12 == 11, tbl[i].x, tbl[i].x);
        end
        idle(3);
        chk_cnt("table_sat", n_sat, 1);

        clr();
        send_pkt(36, 0, 0, 36, 0, -1, 3, 1);
        idle(3);
        chk_cnt("sat_pulses", n_sat, 1);
        chk_cnt("sat_eop", n_eop, 1);

        clr();
        send_pkt(24, 2, 1, 20, 0, -1, 1, 1);
        send_pkt(24, 2, 1, 24, 0, -1, 1, 1);
        idle(3);
        chk_cnt("short_lerr", n_lerr, 1);
        chk_cnt("short_eop", n_eop, 2);
        chk_cnt("short_valid", n_valid, 44);

        clr();
        send_pkt(24, 0, 0, 30, 0, -1, 1, 1);
        send_pkt(24, 0, 0, 24, 0, -1, 1, 1);
        idle(3);
        chk_cnt("long_valid", n_valid, 48);
        chk_cnt("long_lerr", n_lerr, 1);
        chk_cnt("long_eop", n_eop, 2);

        clr();
        send_pkt(36, 0, 0, 36, 25, 10, 0, 1);
        send_pkt(36, 0, 0, 36, 25, -1, 0, 1);
        idle(3);
        chk_cnt("rst_eop", n_eop, 1);
        chk_cnt("rst_lerr", n_lerr, 0);

        for (int p = 0; p < 60; p++) begin
            kind = int'($urandom_range(9));
            dp   = int'($urandom_range(30, 12));
            if (kind <= 4) len = dp;
            else if (kind <= 6) len = int'($urandom_range(dp - 1, 1));
            else if (kind == 7) len = dp + int'($urandom_range(6, 1));
            else if (kind == 8) len = int'($urandom_range(dp - 1, 2));
            else len = 1;
            if ($urandom_range(3) == 0) begin
                drive(1, 0, 1'($urandom), int'($urandom_range(99)), 0);
            end
            send_pkt(dp, int'($urandom_range(15)), int'($urandom_range(63)),
                     len, 20,
                     ($urandom_range(19) == 0) ? int'($urandom_range(len - 1)) : -1,
                     int'($urandom_range(2, 1)), kind != 8);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
